// File: rtl/simmem_pkg.sv
// Shared types, limits and helpers for the simulated-memory write path.
package simmem_pkg;

  localparam int unsigned IdWidth         = 4;
  localparam int unsigned AddrWidth       = 32;
  localparam int unsigned DataWidth       = 32;
  localparam int unsigned StrbWidth       = DataWidth / 8;
  localparam int unsigned BurstLenFieldW  = 8;
  localparam int unsigned BurstSizeFieldW = 3;
  localparam int unsigned BurstTypeFieldW = 2;
  localparam int unsigned XRespWidth      = 2;

  // Largest legal encodings: 4-byte beats, 8-beat bursts.
  localparam int unsigned MaxBurstSizeField = 2;
  localparam int unsigned MaxBurstLenField  = 7;
  localparam int unsigned XBurstEffLenW     = 4;

  localparam int unsigned AddrFifoDepthDefault = 4;

  typedef enum logic [BurstTypeFieldW-1:0] {
    BURST_FIXED    = 2'd0,
    BURST_INCR     = 2'd1,
    BURST_WRAP     = 2'd2,
    BURST_RESERVED = 2'd3
  } burst_type_e;

  typedef enum logic [XRespWidth-1:0] {
    XRESP_OKAY   = 2'd0,
    XRESP_EXOKAY = 2'd1,
    XRESP_SLVERR = 2'd2,
    XRESP_DECERR = 2'd3
  } xresp_e;

  typedef struct packed {
    logic [IdWidth-1:0]         id;
    logic [AddrWidth-1:0]       addr;
    logic [BurstLenFieldW-1:0]  burst_len;
    logic [BurstSizeFieldW-1:0] burst_size;
    burst_type_e                burst_type;
  } waddr_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } wdata_t;

  typedef struct packed {
    logic [IdWidth-1:0]    id;
    logic [XRespWidth-1:0] payload;
  } wrsp_t;

  typedef struct packed {
    logic [IdWidth-1:0]       id;
    logic [XBurstEffLenW-1:0] eff_len;
    logic                     err;
  } waddr_entry_t;

  // Oversized lengths collapse to 0; such addresses are flagged and never end on length.
  function automatic logic [XBurstEffLenW-1:0] get_effective_burst_len(
    input logic [BurstLenFieldW-1:0] burst_len
  );
    if (burst_len > BurstLenFieldW'(MaxBurstLenField)) begin
      return '0;
    end
    return XBurstEffLenW'(burst_len) + XBurstEffLenW'(1);
  endfunction

  function automatic logic addr_has_error(input waddr_t a);
    return (a.burst_size > BurstSizeFieldW'(MaxBurstSizeField)) ||
           (a.burst_len > BurstLenFieldW'(MaxBurstLenField)) ||
           (a.burst_type == BURST_RESERVED) ||
           (a.burst_type == BURST_FIXED);
  endfunction

endpackage

// File: rtl/simmem_waddr_fifo.sv
// Synchronous FIFO holding decoded write-address entries until their data burst completes.
module simmem_waddr_fifo
  import simmem_pkg::*;
#(
  parameter int unsigned Depth = AddrFifoDepthDefault
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  waddr_entry_t data_i,
  input  logic         pop_i,
  output waddr_entry_t data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         single_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  waddr_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o   = (cnt_q == CntW'(Depth));
  assign empty_o  = (cnt_q == '0);
  assign single_o = (cnt_q == CntW'(1));
  // Push is gated on the registered full flag only, so a same-cycle pop never frees a slot.
  assign do_push  = push_i & ~full_o;
  assign do_pop   = pop_i & ~empty_o;
  assign data_o   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/simmem_write_responder.sv
// Pairs queued write addresses with their data bursts and returns one write response per
// burst, in address-acceptance order. Data and strobes are consumed and discarded.
module simmem_write_responder
  import simmem_pkg::*;
#(
  parameter int unsigned AddrFifoDepth = AddrFifoDepthDefault
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  waddr_t waddr_i,
  input  logic   waddr_in_valid_i,
  output logic   waddr_in_ready_o,
  input  wdata_t wdata_i,
  input  logic   wdata_in_valid_i,
  output logic   wdata_in_ready_o,
  output wrsp_t  wrsp_o,
  output logic   wrsp_out_valid_o,
  input  logic   wrsp_out_ready_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEATS = 2'd1;
  localparam logic [1:0] S_RSP   = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [XBurstEffLenW-1:0] beat_cnt_q, beat_cnt_d, beat_cnt_inc;
  wrsp_t                    rsp_q, rsp_d;
  logic                     rsp_valid_q, rsp_valid_d;
  wrsp_t                    pend_q, pend_d;

  waddr_entry_t fifo_wdata, fifo_head;
  logic         fifo_full, fifo_empty, fifo_single, fifo_pop;
  logic         wdata_hs, rsp_hs, len_hit, burst_end, rsp_slot_free;
  wrsp_t        end_rsp;
  logic         unused_bits;

  assign fifo_wdata.id      = waddr_i.id;
  assign fifo_wdata.eff_len = get_effective_burst_len(waddr_i.burst_len);
  assign fifo_wdata.err     = addr_has_error(waddr_i);

  simmem_waddr_fifo #(
    .Depth(AddrFifoDepth)
  ) u_waddr_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (waddr_in_valid_i),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .single_o(fifo_single)
  );

  assign waddr_in_ready_o = ~fifo_full;
  assign wdata_in_ready_o = (state_q == S_BEATS);
  assign wrsp_o           = rsp_q;
  assign wrsp_out_valid_o = rsp_valid_q;

  assign wdata_hs      = wdata_in_valid_i & wdata_in_ready_o;
  assign rsp_hs        = rsp_valid_q & wrsp_out_ready_i;
  assign rsp_slot_free = ~rsp_valid_q | rsp_hs;
  assign beat_cnt_inc  = beat_cnt_q + XBurstEffLenW'(1);

  // Flagged addresses ignore their length field and only finish on an explicit last.
  assign len_hit   = ~fifo_head.err & (beat_cnt_inc == fifo_head.eff_len);
  assign burst_end = wdata_hs & (wdata_i.last | len_hit);
  assign fifo_pop  = burst_end;

  assign end_rsp.id      = fifo_head.id;
  assign end_rsp.payload = (wdata_i.last && len_hit) ? XRESP_OKAY : XRESP_SLVERR;

  assign unused_bits = ^{waddr_i.addr, wdata_i.data, wdata_i.strb};

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    pend_d      = pend_q;

    if (rsp_hs) begin
      rsp_valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_BEATS;
        end
      end

      S_BEATS: begin
        if (burst_end) begin
          beat_cnt_d = '0;
          if (rsp_slot_free) begin
            rsp_d       = end_rsp;
            rsp_valid_d = 1'b1;
            state_d     = fifo_single ? S_IDLE : S_BEATS;
          end else begin
            // Response register still occupied: park the result and stop taking beats.
            pend_d  = end_rsp;
            state_d = S_RSP;
          end
        end else if (wdata_hs) begin
          beat_cnt_d = beat_cnt_inc;
        end
      end

      S_RSP: begin
        if (rsp_hs) begin
          rsp_d       = pend_q;
          rsp_valid_d = 1'b1;
          state_d     = fifo_empty ? S_IDLE : S_BEATS;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      beat_cnt_q  <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      pend_q      <= pend_d;
    end
  end

endmodule

// File: tb/tb_simmem_write_responder.sv
// Scoreboard bench: directed corner cases plus randomized traffic against a queue-based model.
module tb_simmem_write_responder;
  import simmem_pkg::*;

  localparam int unsigned Depth  = 4;
  localparam int          Budget = 500;

  logic   clk = 1'b0;
  logic   rst;
  waddr_t waddr;
  logic   waddr_valid, waddr_ready;
  wdata_t wdata;
  logic   wdata_valid, wdata_ready;
  wrsp_t  wrsp;
  logic   wrsp_valid, wrsp_ready;

  always #5 clk = ~clk;

  simmem_write_responder #(
    .AddrFifoDepth(Depth)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .waddr_i         (waddr),
    .waddr_in_valid_i(waddr_valid),
    .waddr_in_ready_o(waddr_ready),
    .wdata_i         (wdata),
    .wdata_in_valid_i(wdata_valid),
    .wdata_in_ready_o(wdata_ready),
    .wrsp_o          (wrsp),
    .wrsp_out_valid_o(wrsp_valid),
    .wrsp_out_ready_i(wrsp_ready)
  );

  typedef struct {
    int id;
    int len;
    bit err;
  } maddr_t;

  typedef struct {
    int id;
    int payload;
  } mrsp_t;

  maddr_t mq[$];
  mrsp_t  eq[$];
  int     beat_cnt;
  int     checks = 0;
  int     failures = 0;
  int     exp_total = 0;
  int     rsp_seen = 0;
  bit     lat_pend;
  int     lat_id;
  bit     hold_pend;
  wrsp_t  hold_val;
  bit     addr_done, data_done;
  bit     dummy_a, pop_aready;
  int     rcyc;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic bit model_err(input waddr_t a);
    return (int'(a.burst_size) > int'(MaxBurstSizeField)) ||
           (int'(a.burst_len) > int'(MaxBurstLenField)) ||
           (a.burst_type == BURST_RESERVED) || (a.burst_type == BURST_FIXED);
  endfunction

  function automatic waddr_t mk_addr(input int id, input int len, input int size,
                                     input burst_type_e bt);
    waddr_t a;
    a.id         = IdWidth'(id);
    a.addr       = AddrWidth'($urandom);
    a.burst_len  = BurstLenFieldW'(len);
    a.burst_size = BurstSizeFieldW'(size);
    a.burst_type = bt;
    return a;
  endfunction

  function automatic waddr_t rand_addr();
    int len, size, t;
    burst_type_e bt;
    len  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 20)) : int'($urandom_range(0, 7));
    size = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
    t    = int'($urandom_range(0, 9));
    bt   = (t < 8) ? BURST_INCR : burst_type_e'($urandom_range(0, 3));
    return mk_addr(int'($urandom_range(0, 15)), len, size, bt);
  endfunction

  task automatic send_addr(input waddr_t a);
    int n;
    @(posedge clk);
    #1;
    waddr       = a;
    waddr_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!waddr_ready && n < Budget) begin
      n++;
      @(negedge clk);
    end
    check(waddr_ready == 1'b1, "addr_accept", n, Budget);
    @(posedge clk);
    #1;
    waddr_valid = 1'b0;
  endtask

  task automatic send_beat(input bit last, output bit aready_hs);
    int n;
    @(posedge clk);
    #1;
    wdata.data  = DataWidth'($urandom);
    wdata.strb  = StrbWidth'($urandom);
    wdata.last  = last;
    wdata_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!wdata_ready && n < Budget) begin
      n++;
      @(negedge clk);
    end
    check(wdata_ready == 1'b1, "beat_accept", n, Budget);
    aready_hs = waddr_ready;
    @(posedge clk);
    #1;
    wdata_valid = 1'b0;
  endtask

  // Monitor and reference model: every transfer is observed on the falling edge before it lands.
  initial begin
    maddr_t m;
    mrsp_t  e, r;
    bit     on_len;
    forever begin
      @(negedge clk);
      if (rst) begin
        mq.delete();
        eq.delete();
        beat_cnt  = 0;
        lat_pend  = 1'b0;
        hold_pend = 1'b0;
      end else begin
        if (lat_pend) begin
          check(wrsp_valid && int'(wrsp.id) == lat_id, "rsp_latency",
                wrsp_valid ? longint'(wrsp.id) : -1, lat_id);
          lat_pend = 1'b0;
        end
        if (hold_pend) begin
          check(wrsp_valid && wrsp == hold_val, "rsp_hold_stable", longint'(wrsp),
                longint'(hold_val));
          hold_pend = 1'b0;
        end
        if (wrsp_valid) begin
          check(eq.size() != 0, "rsp_unexpected", longint'(wrsp.id), -1);
          if (eq.size() != 0 && wrsp_ready) begin
            e = eq.pop_front();
            check(int'(wrsp.id) == e.id, "rsp_id", wrsp.id, e.id);
            check(int'(wrsp.payload) == e.payload, "rsp_payload", wrsp.payload, e.payload);
            rsp_seen++;
          end else if (!wrsp_ready) begin
            hold_pend = 1'b1;
            hold_val  = wrsp;
          end
        end
        if (wdata_valid && wdata_ready) begin
          check(mq.size() != 0, "beat_without_addr", mq.size(), 1);
          if (mq.size() != 0) begin
            on_len = !mq[0].err && (beat_cnt + 1 == mq[0].len);
            if (wdata.last || on_len) begin
              r.id      = mq[0].id;
              r.payload = (wdata.last && on_len) ? 0 : 2;
              if (!wrsp_valid || wrsp_ready) begin
                lat_pend = 1'b1;
                lat_id   = r.id;
              end
              eq.push_back(r);
              exp_total++;
              void'(mq.pop_front());
              beat_cnt = 0;
            end else begin
              beat_cnt++;
            end
          end
        end
        if (waddr_valid && waddr_ready) begin
          m.id  = int'(waddr.id);
          m.len = int'(waddr.burst_len) + 1;
          m.err = model_err(waddr);
          mq.push_back(m);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    waddr       = '0;
    waddr_valid = 1'b0;
    wdata       = '0;
    wdata_valid = 1'b0;
    wrsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check(waddr_ready == 1'b1, "reset_waddr_ready", waddr_ready, 1);
    check(wdata_ready == 1'b0, "reset_wdata_ready", wdata_ready, 0);
    check(wrsp_valid == 1'b0, "reset_rsp_valid", wrsp_valid, 0);
    check(wrsp == '0, "reset_rsp", longint'(wrsp), 0);

    // Well-formed 4-beat INCR burst.
    send_addr(mk_addr(2, 3, 2, BURST_INCR));
    send_beat(1'b0, dummy_a);
    send_beat(1'b0, dummy_a);
    send_beat(1'b0, dummy_a);
    send_beat(1'b1, dummy_a);

    // Early last, then a normal burst whose count must restart from zero.
    send_addr(mk_addr(10, 3, 2, BURST_INCR));
    send_beat(1'b0, dummy_a);
    send_beat(1'b1, dummy_a);
    send_addr(mk_addr(11, 1, 2, BURST_INCR));
    send_beat(1'b0, dummy_a);
    send_beat(1'b1, dummy_a);

    // Oversized beat size: length ignored, burst runs to last.
    send_addr(mk_addr(9, 1, 3, BURST_INCR));
    send_beat(1'b0, dummy_a);
    send_beat(1'b0, dummy_a);
    send_beat(1'b0, dummy_a);
    send_beat(1'b1, dummy_a);

    // Fill the address queue; the fifth enters only after the first pop.
    for (int i = 0; i < 4; i++) begin
      send_addr(mk_addr(4 + i, 0, 2, BURST_INCR));
    end
    @(negedge clk);
    check(waddr_ready == 1'b0, "fifo_full_ready", waddr_ready, 0);
    fork
      send_addr(mk_addr(8, 0, 2, BURST_INCR));
      begin
        send_beat(1'b1, pop_aready);
        check(pop_aready == 1'b0, "no_bypass_when_full", pop_aready, 0);
        @(negedge clk);
        check(waddr_ready == 1'b1, "ready_after_pop", waddr_ready, 1);
      end
    join
    for (int i = 0; i < 4; i++) begin
      send_beat(1'b1, dummy_a);
    end

    // Back-pressured responses: second result parks, then both drain back to back.
    repeat (4) @(posedge clk);
    #1;
    wrsp_ready = 1'b0;
    send_addr(mk_addr(1, 0, 2, BURST_INCR));
    send_addr(mk_addr(3, 0, 2, BURST_INCR));
    send_beat(1'b1, dummy_a);
    send_beat(1'b1, dummy_a);
    @(negedge clk);
    check(wdata_ready == 1'b0, "parked_wdata_ready", wdata_ready, 0);
    check(wrsp_valid && wrsp.id == 4'd1, "parked_first_rsp", wrsp.id, 1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    wrsp_ready = 1'b1;
    @(negedge clk);
    check(wrsp_valid && wrsp.id == 4'd1, "b2b_first", wrsp_valid ? longint'(wrsp.id) : -1, 1);
    @(negedge clk);
    check(wrsp_valid && wrsp.id == 4'd3, "b2b_second", wrsp_valid ? longint'(wrsp.id) : -1, 3);

    // Reset mid-burst discards everything queued.
    send_addr(mk_addr(12, 3, 2, BURST_INCR));
    send_addr(mk_addr(13, 1, 2, BURST_INCR));
    send_beat(1'b0, dummy_a);
    send_beat(1'b0, dummy_a);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check(waddr_ready == 1'b1, "midreset_waddr_ready", waddr_ready, 1);
    check(wdata_ready == 1'b0, "midreset_wdata_ready", wdata_ready, 0);
    check(wrsp_valid == 1'b0, "midreset_rsp_valid", wrsp_valid, 0);
    check(wrsp == '0, "midreset_rsp", longint'(wrsp), 0);
    repeat (5) @(negedge clk);
    check(wrsp_valid == 1'b0, "midreset_no_rsp", wrsp_valid, 0);
    send_addr(mk_addr(14, 1, 2, BURST_INCR));
    send_beat(1'b0, dummy_a);
    send_beat(1'b1, dummy_a);

    // Randomized concurrent traffic on all three channels.
    addr_done = 1'b0;
    data_done = 1'b0;
    rcyc      = 0;
    fork
      begin
        for (int i = 0; i < 120; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          send_addr(rand_addr());
        end
        addr_done = 1'b1;
      end
      begin
        while (!(addr_done && mq.size() == 0) && rcyc < 20000) begin
          @(posedge clk);
          #1;
          wdata_valid = ($urandom_range(0, 3) != 0);
          wdata.data  = DataWidth'($urandom);
          wdata.strb  = StrbWidth'($urandom);
          wdata.last  = ($urandom_range(0, 4) == 0);
          rcyc++;
        end
        @(posedge clk);
        #1;
        wdata_valid = 1'b0;
        check(mq.size() == 0, "random_drain", mq.size(), 0);
        data_done = 1'b1;
      end
      begin
        while (!data_done) begin
          @(posedge clk);
          #1;
          wrsp_ready = ($urandom_range(0, 2) != 0);
        end
        wrsp_ready = 1'b1;
      end
    join

    repeat (20) @(posedge clk);
    @(negedge clk);
    check(eq.size() == 0, "all_rsp_drained", eq.size(), 0);
    check(rsp_seen == exp_total, "rsp_count", rsp_seen, exp_total);
    check(wrsp_valid == 1'b0, "final_rsp_idle", wrsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
